// File: rtl/uart_wb_bridge_if.sv
// Byte-stream and Wishbone signals between the UART bridge and its neighbours.
// The bridge takes the master modport. The UART side and the bus slave take the slave modport.
interface uart_wb_bridge_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        rx_drop_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i, wb_err_i,
    output tx_data_o, tx_valid_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o,
           wb_stb_o, wb_we_o, rx_drop_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  tx_data_o, tx_valid_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o,
           wb_stb_o, wb_we_o, rx_drop_o
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// UART byte-stream to Wishbone master bridge.
// Command format: 'W' plus a 4-byte address plus 4 data bytes, or 'R' plus a 4-byte address.
// The bridge replies with status 'K' or 'E'. A successful read also returns 4 data bytes.
module uart_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk_sys_i,
  input logic              reset_sys_i,
  uart_wb_bridge_if.master bus
);
  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [7:0]  ST_K     = 8'h4B;
  localparam logic [7:0]  ST_E     = 8'h45;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_STATUS, S_RDATA} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        wr_mode;
  logic [31:0] adr_q, wdat_q, rdat_q;
  logic [7:0]  status_q;
  logic [15:0] tmo_q;
  logic        drop_q;
  logic        term, tmo_hit;

  assign term    = bus.wb_ack_i | bus.wb_err_i;
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next-state and byte counter; the counter is shared by ADDR/WDATA/RDATA
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (bus.rx_valid_i && (bus.rx_data_i == CMD_W || bus.rx_data_i == CMD_R)) begin
        state_n = S_ADDR;
        cnt_n   = 2'd0;
      end
      S_ADDR: if (bus.rx_valid_i) begin
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) state_n = wr_mode ? S_WDATA : S_BUS;
      end
      S_WDATA: if (bus.rx_valid_i) begin
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) state_n = S_BUS;
      end
      S_BUS: if (term || tmo_hit) state_n = S_STATUS;
      S_STATUS: if (bus.tx_ready_i) begin
        state_n = (!wr_mode && status_q == ST_K) ? S_RDATA : S_IDLE;
        cnt_n   = 2'd0;
      end
      S_RDATA: if (bus.tx_ready_i) begin
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 2'd0;
      end
    endcase
  end

  // State register plus command/response datapath
  always_ff @(posedge clk_sys_i) begin
    if (!reset_sys_i) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      wr_mode  <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      tmo_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      drop_q <= bus.rx_valid_i && (state == S_BUS || state == S_STATUS || state == S_RDATA);
      // The counter is held at zero outside BUS, so it is already clear when BUS is entered
      tmo_q  <= (state == S_BUS) ? tmo_q + 16'd1 : 16'd0;
      if (state == S_IDLE && bus.rx_valid_i) begin
        if (bus.rx_data_i == CMD_W) wr_mode <= 1'b1;
        if (bus.rx_data_i == CMD_R) wr_mode <= 1'b0;
      end
      if (state == S_ADDR && bus.rx_valid_i)  adr_q  <= {adr_q[23:0], bus.rx_data_i};
      if (state == S_WDATA && bus.rx_valid_i) wdat_q <= {wdat_q[23:0], bus.rx_data_i};
      // err beats ack; any termination beats the timeout on the same edge
      if (state == S_BUS) begin
        if (bus.wb_err_i) status_q <= ST_E;
        else if (bus.wb_ack_i) begin
          status_q <= ST_K;
          if (!wr_mode) rdat_q <= bus.wb_dat_i;
        end else if (tmo_hit) status_q <= ST_E;
      end
    end
  end

  assign bus.wb_cyc_o   = (state == S_BUS);
  assign bus.wb_stb_o   = (state == S_BUS);
  assign bus.wb_sel_o   = (state == S_BUS) ? 4'hF : 4'h0;
  assign bus.wb_we_o    = wr_mode;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = wdat_q;
  assign bus.tx_valid_o = (state == S_STATUS) || (state == S_RDATA);
  assign bus.rx_drop_o  = drop_q;

  // Response byte select: status first, then the read word MSB first
  always_comb begin
    bus.tx_data_o = 8'h00;
    if (state == S_STATUS) bus.tx_data_o = status_q;
    else if (state == S_RDATA) begin
      case (cnt)
        2'd0:    bus.tx_data_o = rdat_q[31:24];
        2'd1:    bus.tx_data_o = rdat_q[23:16];
        2'd2:    bus.tx_data_o = rdat_q[15:8];
        default: bus.tx_data_o = rdat_q[7:0];
      endcase
    end
  end
endmodule
